// File: rtl/fxp_pkg.sv
// +----------------------------------------------------------------------+
// | fxp_pkg : width helpers and shared types for the fixed-point pipeline |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fxp_pkg;

    // Operand carries a double-precision fraction; the result keeps half of it.
    function automatic int op_width(input int intw, input int ratw);
        return intw + 2 * ratw;
    endfunction

    function automatic int res_width(input int intw, input int ratw);
        return intw + ratw;
    endfunction

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

endpackage

`default_nettype wire

// File: rtl/round.sv
// +----------------------------------------------------------------------+
// | round : round-half-up of a 2*RATW fraction operand to RATW bits       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module round #(
    parameter int INTW = 10,
    parameter int RATW = 2
) (
    input  logic [INTW+2*RATW-1:0] op_i,
    output logic [INTW+RATW:0]     res_o
);

    localparam int SW = INTW + 2 * RATW + 1;
    localparam logic [SW-1:0] HALF = SW'(1) << (RATW - 1);

    logic [SW-1:0] sum_w;

    // One extra bit keeps the carry so the caller can detect overflow.
    assign sum_w = {1'b0, op_i} + HALF;
    assign res_o = sum_w[SW-1:RATW];

endmodule

`default_nettype wire

// File: rtl/round_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | round_rr_arbiter : round-robin share of one round datapath, 1-deep    |
// | registered valid/ready output stage.  Rev 1.0                         |
// +----------------------------------------------------------------------+
`default_nettype none

module round_rr_arbiter
    import fxp_pkg::*;
#(
    parameter int INTW = 10,
    parameter int RATW = 2,
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREQ-1:0]                     req_valid,
    input  logic [NREQ*(INTW+2*RATW)-1:0]       req_data,
    output logic [NREQ-1:0]                     req_ready,
    output logic                                rsp_valid,
    output logic [INTW+RATW-1:0]                rsp_data,
    output logic [IDW-1:0]                      rsp_id,
    input  logic                                rsp_ready,
    output logic [15:0]                         grant_cnt
);

    localparam int OPW = op_width(INTW, RATW);
    localparam int RSW = res_width(INTW, RATW);
    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

    rsp_state_e          state_q, state_d;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      id_q;
    logic [RSW-1:0]      data_q;
    logic [15:0]         cnt_q;

    logic                any_valid_w;
    logic                grant_w;
    logic [2*NREQ-1:0]   dbl_w;
    logic [NREQ-1:0]     rot_w;
    logic [IDW-1:0]      pick_w;
    logic [IDW:0]        win_sum_w;
    logic [IDW-1:0]      win_w;
    logic [IDW:0]        nxt_sum_w;
    logic [IDW-1:0]      ptr_d;
    logic [OPW-1:0]      op_w;
    logic [RSW:0]        rnd_w;
    logic [RSW-1:0]      sat_w;

    assign any_valid_w = |req_valid;
    assign grant_w     = rst_n && any_valid_w && ((state_q == ST_EMPTY) || rsp_ready);

    // Rotate so ptr sits at bit 0, pick lowest set bit, then map back.
    always_comb begin
        dbl_w  = {req_valid, req_valid} >> ptr_q;
        rot_w  = dbl_w[NREQ-1:0];
        pick_w = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_w[i]) pick_w = IDW'(i);
        end
        win_sum_w = {1'b0, ptr_q} + {1'b0, pick_w};
        if (win_sum_w >= NREQ_W) win_sum_w = win_sum_w - NREQ_W;
        win_w = win_sum_w[IDW-1:0];
        nxt_sum_w = {1'b0, win_w} + (IDW + 1)'(1);
        if (nxt_sum_w >= NREQ_W) nxt_sum_w = nxt_sum_w - NREQ_W;
        ptr_d = nxt_sum_w[IDW-1:0];
    end

    always_comb begin
        req_ready = '0;
        if (grant_w) req_ready[win_w] = 1'b1;
    end

    always_comb begin
        op_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_w) op_w = req_data[i*OPW +: OPW];
        end
    end

    round #(
        .INTW (INTW),
        .RATW (RATW)
    ) u_round (
        .op_i  (op_w),
        .res_o (rnd_w)
    );

    assign sat_w = rnd_w[RSW] ? {RSW{1'b1}} : rnd_w[RSW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (any_valid_w) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready && !any_valid_w) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q == ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            id_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else if (grant_w) begin
            ptr_q  <= ptr_d;
            id_q   <= win_w;
            data_q <= sat_w;
            cnt_q  <= cnt_q + 16'd1;
        end
    end

    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign grant_cnt = cnt_q;

endmodule

`default_nettype wire
